// File: rtl/wasm_pkg.sv
// Shared LEB128 constants, state encoding and sizing helper for the result
// transmit path and the CPU immediate decoder.
package wasm_pkg;

  localparam int LEB_CONT_BIT = 7;
  localparam int LEB_SIGN_BIT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } leb_state_e;

  function automatic int leb_max_bytes(input int w);
    return (w + 6) / 7;
  endfunction

endpackage

// File: rtl/leb_sbyte_gen.sv
// One step of signed LEB128 encoding: low 7 bits, arithmetic-shifted remainder,
// and whether this group terminates the value.
module leb_sbyte_gen
  import wasm_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] sr,
  output logic [6:0]       b,
  output logic [WIDTH-1:0] nxt,
  output logic             done
);

  assign b   = sr[6:0];
  assign nxt = {{7{sr[WIDTH-1]}}, sr[WIDTH-1:7]};
  // Stop once the remainder is pure sign and the emitted sign bit agrees with it.
  assign done = ((nxt == '0) && !b[LEB_SIGN_BIT]) || ((&nxt) && b[LEB_SIGN_BIT]);

endmodule

// File: rtl/result_leb_tx.sv
// Pops CPU results one at a time and streams each as signed LEB128 bytes
// over a valid/ready byte interface.
module result_leb_tx
  import wasm_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int MAX_BYTES = leb_max_bytes(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] result,
  input  logic             result_empty,
  output logic             result_pop,
  input  logic             enable,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [15:0]      sent_count
);

  localparam int CW = $clog2(MAX_BYTES + 1);

  leb_state_e       state_r;
  logic [WIDTH-1:0] sr_r;
  logic [CW-1:0]    cnt_r;

  logic [6:0]       gen_b_s;
  logic [WIDTH-1:0] gen_nxt_s;
  logic             gen_done_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic             last_s;

  leb_sbyte_gen #(.WIDTH(WIDTH)) u_gen (
    .sr   (sr_r),
    .b    (gen_b_s),
    .nxt  (gen_nxt_s),
    .done (gen_done_s)
  );

  // The pop must coincide with the capture edge, so it is decoded from state.
  assign result_pop = reset && (state_r == IDLE) && enable && !result_empty;
  assign busy       = (state_r != IDLE);

  // Byte index of the byte being formed and the forced-last length guard.
  always_comb begin
    cnt_nxt_s = CW'(1);
    if (state_r == LOAD) begin
      cnt_nxt_s = CW'(1);
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
    last_s = gen_done_s || (cnt_nxt_s == CW'(MAX_BYTES));
  end

  // Sequencer: capture on pop, form the first byte, then stream under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      sr_r       <= '0;
      cnt_r      <= '0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      sent_count <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (result_pop) begin
            sr_r    <= result;
            state_r <= LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          out_data  <= {~last_s, gen_b_s};
          out_last  <= last_s;
          out_valid <= 1'b1;
          sr_r      <= gen_nxt_s;
          cnt_r     <= cnt_nxt_s;
          state_r   <= SEND;
        end
        SEND: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              sent_count <= sent_count + 16'd1;
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              state_r    <= IDLE;
            end else begin
              out_data <= {~last_s, gen_b_s};
              out_last <= last_s;
              sr_r     <= gen_nxt_s;
              cnt_r    <= cnt_nxt_s;
            end
          end else begin
            state_r <= SEND;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_leb_tx.sv
// Self-checking bench for result_leb_tx: a queue models the CPU result stack and
// expected bytes come from a minimal-length signed LEB128 reference.
module tb_result_leb_tx;

  logic        clk;
  logic        reset;
  logic [63:0] result;
  logic        result_empty;
  logic        result_pop;
  logic        enable;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic [15:0] sent_count;

  result_leb_tx dut (
    .clk          (clk),
    .reset        (reset),
    .result       (result),
    .result_empty (result_empty),
    .result_pop   (result_pop),
    .enable       (enable),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .sent_count   (sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          errors   = 0;
  int          pops     = 0;
  int          accepted = 0;
  int          sent_exp = 0;
  bit          rnd      = 1'b0;
  logic [63:0] stk[$];
  logic [8:0]  exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: shortest n whose 7n-bit two's complement range holds v.
  task automatic enc_push(input logic [63:0] v);
    longint sv;
    longint t;
    int     n;
    logic [6:0] b;
    sv = longint'(v);
    n  = 10;
    for (int k = 9; k >= 1; k--) begin
      t = sv <<< (64 - 7 * k);
      t = t >>> (64 - 7 * k);
      if (t == sv) n = k;
    end
    for (int i = 0; i < n; i++) begin
      t = sv >>> (7 * i);
      b = t[6:0];
      exp_q.push_back({(i == n - 1), (i != n - 1), b});
    end
  endtask

  task automatic drive_stack();
    result       = (stk.size() != 0) ? stk[0] : 64'd0;
    result_empty = (stk.size() == 0);
  endtask

  task automatic cycle();
    logic       pop_p, hs_p, v_p, l_p, e_p, busy_p;
    logic [7:0] d_p;
    logic [8:0] e;
    @(negedge clk);
    pop_p  = result_pop;
    v_p    = out_valid;
    hs_p   = out_valid & out_ready;
    d_p    = out_data;
    l_p    = out_last;
    e_p    = result_empty;
    busy_p = busy;
    @(posedge clk);
    #1;
    if (pop_p) begin
      chk("pop_nonempty", 64'(e_p), 64'd0);
      chk("pop_in_idle", 64'(busy_p), 64'd0);
      if (stk.size() != 0) enc_push(stk.pop_front());
      pops++;
    end
    if (hs_p) begin
      accepted++;
      checks++;
      assert (exp_q.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_byte: observed %02h expected none", d_p);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("byte", 64'(d_p), 64'(e[7:0]));
        chk("last", 64'(l_p), 64'(e[8]));
        if (e[8]) begin
          sent_exp++;
          chk("busy_after_last", 64'(busy), 64'd0);
          chk("sent_count", 64'(sent_count), 64'(sent_exp[15:0]));
        end
      end
    end else if (v_p) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(out_data), 64'(d_p));
      chk("hold_last", 64'(out_last), 64'(l_p));
    end
    drive_stack();
    if (rnd) begin
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((stk.size() != 0 || exp_q.size() != 0 || busy) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    assert (n < budget)
    else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d cycles expected < %0d", n, budget);
    end
  endtask

  initial begin
    int          p0;
    int          n;
    int          w;
    logic [63:0] v;

    reset     = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b1;
    drive_stack();
    #12;
    chk("rst_pop", 64'(result_pop), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sent", 64'(sent_count), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Empty stack with enable high: nothing happens.
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("empty_pop", 64'(result_pop), 64'd0);
      chk("empty_valid", 64'(out_valid), 64'd0);
    end

    // Stack holds 0 but enable low: no pop.
    enable = 1'b0;
    stk.push_back(64'd0);
    drive_stack();
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("dis_pop", 64'(result_pop), 64'd0);
      chk("dis_valid", 64'(out_valid), 64'd0);
    end
    chk("dis_sent", 64'(sent_count), 64'd0);

    p0     = pops;
    enable = 1'b1;
    drain(50);
    chk("zero_pops", 64'(pops - p0), 64'd1);
    chk("zero_sent", 64'(sent_count), 64'd1);

    p0 = pops;
    stk.push_back(64'd624485);
    stk.push_back(-64'sd123456);
    stk.push_back(64'd64);
    stk.push_back(-64'sd1);
    drive_stack();
    drain(200);
    chk("four_pops", 64'(pops - p0), 64'd4);
    chk("four_sent", 64'(sent_count), 64'd5);

    stk.push_back(64'h8000_0000_0000_0000);
    stk.push_back(64'h7FFF_FFFF_FFFF_FFFF);
    drive_stack();
    drain(200);

    // Backpressure on the first byte of 624485.
    p0        = pops;
    out_ready = 1'b0;
    stk.push_back(64'd624485);
    drive_stack();
    n = 0;
    while (!out_valid && n < 10) begin
      cycle();
      n++;
    end
    chk("bp_first", 64'(out_data), 64'hE5);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_data", 64'(out_data), 64'hE5);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_nopop", 64'(result_pop), 64'd0);
    end
    stk.push_back(64'd1);
    drive_stack();
    out_ready = 1'b1;
    drain(100);
    chk("bp_pops", 64'(pops - p0), 64'd2);

    // Randomized values, handshakes and enable.
    rnd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w = $urandom_range(1, 64);
      v = {$urandom, $urandom};
      if (w < 64) begin
        v = v & ((64'd1 << w) - 64'd1);
        if (v[w-1]) v = v | ~((64'd1 << w) - 64'd1);
      end
      stk.push_back(v);
      drive_stack();
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) cycle();
    end
    drain(4000);
    rnd       = 1'b0;
    out_ready = 1'b1;
    enable    = 1'b1;
    chk("rnd_sent", 64'(sent_count), 64'(sent_exp[15:0]));

    // Reset mid-encode after the second byte of 624485.
    accepted = 0;
    stk.push_back(64'd624485);
    drive_stack();
    n = 0;
    while (accepted < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("pre_reset_bytes", 64'(accepted), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pop", 64'(result_pop), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_last", 64'(out_last), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_sent", 64'(sent_count), 64'd0);
    exp_q.delete();
    stk.delete();
    sent_exp = 0;
    drive_stack();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("post_rst_valid", 64'(out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
